// File: rtl/pc_attacker.sv
// pc_attacker: PC shot engine; picks an untried cell (LFSR seed + linear scan), resolves hit/miss, tracks player HP.
// Ports: clk/reset (sync, active-high); start requests a shot; new_game clears the tried map and HP;
// ship_map is the player's ship bitmap; busy/done/shot_valid/hit/exhausted report the shot;
// shot_row/shot_col hold the last fired cell; hp_player is the remaining player HP.
// Optional macro PC_ATTACK_HUNT_EN: after a hit, probe untried neighbours (up, right, down, left) first.
module pc_attacker #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int IDXW = 5,
  parameter logic [2:0] HP_INIT = 3'd5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic new_game,
  input  logic [ROWS*COLS-1:0] ship_map,
  output logic busy,
  output logic done,
  output logic shot_valid,
  output logic hit,
  output logic exhausted,
  output logic [$clog2(ROWS)-1:0] shot_row,
  output logic [$clog2(COLS)-1:0] shot_col,
  output logic [2:0] hp_player
);
  localparam int N = ROWS*COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = IDXW+1;
  localparam logic [PW-1:0] NP = PW'(N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N-1);
  localparam logic [IDXW-1:0] CI = IDXW'(COLS);
  typedef enum logic [1:0] {IDLE, PICK, SCAN, REPORT} state_t;
  state_t state_q, state_d;
  logic [N-1:0] tried_q, tried_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [IDXW-1:0] cand_q, cand_d, rnd, pick;
  logic [PW-1:0] probe_q, probe_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic hit_q, hit_d, valid_q, valid_d, exh_q, exh_d;
  logic [2:0] hp_q, hp_d;
  // out-of-board LFSR values fold onto cell 0
  assign rnd = ({1'b0, lfsr_q[IDXW-1:0]} >= NP) ? '0 : lfsr_q[IDXW-1:0];
  assign lfsr_d = (state_q == PICK) ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
`ifdef PC_ATTACK_HUNT_EN
  logic pend_q, pend_d, fire, u_ok, r_ok, d_ok, l_ok, nb_ok;
  logic [IDXW-1:0] last_q, last_d, up, rt, dn, lf;
  logic [RW-1:0] lr;
  logic [CW-1:0] lc;
  assign lr = RW'(last_q / CI);
  assign lc = CW'(last_q % CI);
  assign up = last_q - CI;
  assign rt = last_q + 1'b1;
  assign dn = last_q + CI;
  assign lf = last_q - 1'b1;
  // board-edge tests guard the tried lookups, so wrapped indices are never selected
  assign u_ok = lr != '0 && !tried_q[up];
  assign r_ok = lc != CW'(COLS-1) && !tried_q[rt];
  assign d_ok = lr != RW'(ROWS-1) && !tried_q[dn];
  assign l_ok = lc != '0 && !tried_q[lf];
  assign nb_ok = pend_q && (u_ok || r_ok || d_ok || l_ok);
  assign pick = !nb_ok ? rnd : u_ok ? up : r_ok ? rt : d_ok ? dn : lf;
  assign fire = state_q == SCAN && probe_q != NP && !tried_q[cand_q];
  always_comb begin
    pend_d = (state_q == PICK) ? nb_ok : pend_q;
    last_d = last_q;
    if (fire && ship_map[cand_q]) begin
      pend_d = 1'b1;
      last_d = cand_q;
    end
    if (new_game) pend_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      last_q <= '0;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
    end
  end
`else
  assign pick = rnd;
`endif
  always_comb begin
    state_d = state_q;
    tried_d = tried_q;
    cand_d = cand_q;
    probe_d = probe_q;
    row_d = row_q;
    col_d = col_q;
    hp_d = hp_q;
    hit_d = 1'b0;
    valid_d = 1'b0;
    exh_d = 1'b0;
    case (state_q)
      IDLE: state_d = start ? PICK : IDLE;
      PICK: begin
        cand_d = pick;
        probe_d = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (probe_q == NP) begin
          exh_d = 1'b1;
          state_d = REPORT;
        end else if (!tried_q[cand_q]) begin
          tried_d[cand_q] = 1'b1;
          row_d = RW'(cand_q / CI);
          col_d = CW'(cand_q % CI);
          hit_d = ship_map[cand_q];
          valid_d = 1'b1;
          hp_d = (ship_map[cand_q] && hp_q != 3'd0) ? hp_q - 3'd1 : hp_q;
          state_d = REPORT;
        end else begin
          cand_d = (cand_q == LAST) ? '0 : cand_q + 1'b1;
          probe_d = probe_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (new_game) begin
      state_d = IDLE;
      tried_d = '0;
      hp_d = HP_INIT;
      row_d = row_q;
      col_d = col_q;
      hit_d = 1'b0;
      valid_d = 1'b0;
      exh_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tried_q <= '0;
      lfsr_q <= LFSR_SEED;
      cand_q <= '0;
      probe_q <= '0;
      row_q <= '0;
      col_q <= '0;
      hit_q <= 1'b0;
      valid_q <= 1'b0;
      exh_q <= 1'b0;
      hp_q <= HP_INIT;
    end else begin
      state_q <= state_d;
      tried_q <= tried_d;
      lfsr_q <= lfsr_d;
      cand_q <= cand_d;
      probe_q <= probe_d;
      row_q <= row_d;
      col_q <= col_d;
      hit_q <= hit_d;
      valid_q <= valid_d;
      exh_q <= exh_d;
      hp_q <= hp_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == REPORT;
  assign shot_valid = valid_q;
  assign hit = hit_q;
  assign exhausted = exh_q;
  assign shot_row = row_q;
  assign shot_col = col_q;
  assign hp_player = hp_q;
endmodule

// File: tb/tb_pc_attacker.sv
// tb_pc_attacker: directed self-checking bench for pc_attacker (5x5 board, seed 8'hA5).
module tb_pc_attacker;
  logic clk, reset, start, new_game;
  logic [24:0] ship_map;
  logic busy, done, shot_valid, hit, exhausted;
  logic [2:0] shot_row, shot_col, hp_player;
  int checks = 0;
  int errors = 0;

  pc_attacker dut (
    .clk(clk), .reset(reset), .start(start), .new_game(new_game), .ship_map(ship_map),
    .busy(busy), .done(done), .shot_valid(shot_valid), .hit(hit), .exhausted(exhausted),
    .shot_row(shot_row), .shot_col(shot_col), .hp_player(hp_player)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    new_game = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // returns cycles from the start-sampling edge to the done cycle (2 = no probing)
  task automatic shoot(output int lat);
    int g = 0;
    while (busy && g < 60) begin
      step();
      g++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, shot_valid, hit, exhausted} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {busy, done, shot_valid, hit, exhausted});
    end
    checks++;
    if (shot_row !== 3'd0 || shot_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_rowcol got %0d,%0d want 0,0", shot_row, shot_col);
    end
    checks++;
    if (hp_player !== 3'd5) begin
      errors++;
      $display("FAIL reset_hp got %0d want 5", hp_player);
    end
  endtask

  task automatic test_miss();
    int lat;
    do_reset();
    ship_map = '0;
    shoot(lat);
    checks++;
    if (lat !== 2 || shot_row !== 3'd1 || shot_col !== 3'd0) begin
      errors++;
      $display("FAIL miss_shot got lat %0d row %0d col %0d want 2 1 0", lat, shot_row, shot_col);
    end
    checks++;
    if ({done, shot_valid, hit, exhausted} !== 4'b1100 || hp_player !== 3'd5) begin
      errors++;
      $display("FAIL miss_report got %b hp %0d want 1100 hp 5", {done, shot_valid, hit, exhausted}, hp_player);
    end
    step();
    checks++;
    if ({busy, done, shot_valid} !== 3'b000 || shot_row !== 3'd1) begin
      errors++;
      $display("FAIL miss_after got %b row %0d want 000 row 1", {busy, done, shot_valid}, shot_row);
    end
  endtask

  task automatic test_hit();
    int lat;
    do_reset();
    ship_map = 25'd1 << 5;
    shoot(lat);
    checks++;
    if (lat !== 2 || hit !== 1'b1 || hp_player !== 3'd4) begin
      errors++;
      $display("FAIL hit_report got lat %0d hit %b hp %0d want 2 1 4", lat, hit, hp_player);
    end
    step();
    checks++;
    if (hit !== 1'b0 || hp_player !== 3'd4) begin
      errors++;
      $display("FAIL hit_after got hit %b hp %0d want 0 4", hit, hp_player);
    end
  endtask

  task automatic test_scan();
    int exp_idx[10] = '{5, 10, 21, 11, 20, 9, 19, 7, 14, 0};
    int exp_lat[10] = '{2, 2, 2, 3, 2, 2, 2, 2, 2, 2};
    int lat;
    do_reset();
    ship_map = '0;
    for (int i = 0; i < 10; i++) begin
      shoot(lat);
      checks++;
      if (lat !== exp_lat[i] || shot_row !== exp_idx[i] / 5 || shot_col !== exp_idx[i] % 5 || shot_valid !== 1'b1) begin
        errors++;
        $display("FAIL scan_shot%0d got lat %0d row %0d col %0d valid %b want %0d %0d %0d 1",
                 i, lat, shot_row, shot_col, shot_valid, exp_lat[i], exp_idx[i] / 5, exp_idx[i] % 5);
      end
    end
  endtask

  task automatic test_exhaust();
    int lat;
    int bad = 0;
    do_reset();
    ship_map = '1;
    for (int i = 0; i < 25; i++) begin
      shoot(lat);
      if (done !== 1'b1 || shot_valid !== 1'b1 || hit !== 1'b1) bad++;
      if (i == 4) begin
        checks++;
        if (hp_player !== 3'd0) begin
          errors++;
          $display("FAIL exh_hp5 got %0d want 0", hp_player);
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL exh_fires got %0d bad shots want 0", bad);
    end
    checks++;
    if (hp_player !== 3'd0) begin
      errors++;
      $display("FAIL exh_hp25 got %0d want 0", hp_player);
    end
    shoot(lat);
    checks++;
    if (lat !== 27 || {done, shot_valid, hit, exhausted} !== 4'b1001 || hp_player !== 3'd0) begin
      errors++;
      $display("FAIL exh_report got lat %0d flags %b hp %0d want 27 1001 0", lat, {done, shot_valid, hit, exhausted}, hp_player);
    end
  endtask

  // runs straight after test_exhaust: every cell is tried and hp is 0
  task automatic test_new_game();
    int lat;
    int seen = 0;
    ship_map = '0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    checks++;
    if ({busy, done, shot_valid, exhausted} !== 4'b0 || hp_player !== 3'd5) begin
      errors++;
      $display("FAIL ng_abort got %b hp %0d want 0000 hp 5", {busy, done, shot_valid, exhausted}, hp_player);
    end
    for (int i = 0; i < 30; i++) begin
      if (done) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL ng_no_done got %0d pulses want 0", seen);
    end
    shoot(lat);
    checks++;
    if (lat !== 2 || shot_valid !== 1'b1 || exhausted !== 1'b0) begin
      errors++;
      $display("FAIL ng_reuse got lat %0d valid %b exh %b want 2 1 0", lat, shot_valid, exhausted);
    end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    ship_map = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ign_done got %b want 1", done);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_queued got busy %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] mask = '0;
    do_reset();
    ship_map = '0;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      mask[c] = done;
    end
    start = 1'b0;
    checks++;
    if (mask !== 15'b000_1000_1000_1000) begin
      errors++;
      $display("FAIL b2b_done_mask got %b want 000100010001000", mask);
    end
  endtask

`ifdef PC_ATTACK_HUNT_EN
  task automatic test_hunt();
    int exp_idx[5] = '{5, 0, 6, 10, 20};
    int lat;
    do_reset();
    ship_map = 25'd1 << 5;
    for (int i = 0; i < 5; i++) begin
      shoot(lat);
      checks++;
      if (lat !== 2 || shot_row !== exp_idx[i] / 5 || shot_col !== exp_idx[i] % 5) begin
        errors++;
        $display("FAIL hunt_shot%0d got lat %0d row %0d col %0d want 2 %0d %0d",
                 i, lat, shot_row, shot_col, exp_idx[i] / 5, exp_idx[i] % 5);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    new_game = 1'b0;
    ship_map = '0;
    test_reset();
    test_miss();
    test_hit();
    test_scan();
    test_exhaust();
    test_new_game();
    test_busy_ignore();
    test_back_to_back();
`ifdef PC_ATTACK_HUNT_EN
    test_hunt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_attacker.md
# pc_attacker

Computer-opponent attack engine for the Battleship game. The turn controller pulses `start` when the PC's turn begins. The block then picks an untried cell on the player's board, resolves hit or miss against the player's ship map, and updates the player's hit points. It returns a one-cycle `done` report, which is the handshake the turn controller waits on before evaluating `hp_player`.

## Interface
- `ROWS`, default 5: board rows.
- `COLS`, default 5: board columns; N = ROWS*COLS cells, index = row*COLS + col.
- `IDXW`, default 5: cell index width; must satisfy 2^IDXW ≥ N.
- `HP_INIT`, default 3'd5: player hit points after reset or `new_game`.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request one PC shot; sampled only in IDLE.
- `new_game` in 1: clear the tried map, reload hit points, return to IDLE.
- `ship_map` in N: bit i = 1 means the player has a ship in cell i; must be stable while `busy`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle report strobe.
- `shot_valid` out 1: a shot was fired (qualifies `shot_row`, `shot_col`, `hit`); valid with `done`.
- `hit` out 1: the fired cell held a ship; valid with `done`.
- `exhausted` out 1: all N cells were already tried; valid with `done`.
- `shot_row` out $clog2(ROWS): row of the last shot.
- `shot_col` out $clog2(COLS): column of the last shot.
- `hp_player` out 3: player hit points remaining.

## Operation
- States: IDLE, PICK, SCAN, REPORT. Outputs after reset: state IDLE, `busy`/`done`/`shot_valid`/`hit`/`exhausted` = 0, `shot_row`/`shot_col` = 0, `hp_player` = HP_INIT, tried map all 0, LFSR = LFSR_SEED, probe counter = 0.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Shifts left, feedback bit = b7^b5^b4^b3 enters bit 0. Advances only on exit from PICK.
- IDLE → PICK when `start` = 1.
- PICK:
  - Candidate = LFSR[IDXW-1:0]; if candidate ≥ N, candidate = 0.
  - Probe counter cleared. Next state SCAN.
- SCAN, one cell per cycle:
  - Candidate untried: set its tried bit; register `shot_row` and `shot_col`; `hit` = ship_map[candidate]; if hit and `hp_player` > 0, decrement `hp_player`. Go to REPORT with `shot_valid` = 1.
  - Candidate tried: candidate = (candidate+1) wraps N-1 → 0; probe counter + 1.
  - Probe counter reaches N: REPORT with `shot_valid` = 0, `hit` = 0, `exhausted` = 1. Tried map and hit points are left unchanged.
- REPORT: `done` = 1 for exactly this cycle, then IDLE. `shot_valid`, `hit` and `exhausted` are high only during REPORT. `shot_row`/`shot_col` hold until the next shot.
- `hp_player` saturates at 0. A hit on a cell when `hp_player` = 0 still reports `hit` = 1.
- `start` outside IDLE is ignored and not queued.
- `new_game` in any state:
  - Next cycle: IDLE, tried map cleared, `hp_player` = HP_INIT, report outputs 0.
  - LFSR and `shot_row`/`shot_col` are not reset.
  - Has priority over `start` in the same cycle.
- `reset` has priority over everything else.

## Timing
- `start` sampled at edge k → PICK in cycle k+1 → SCAN from k+2.
- Untried first candidate: `done` high in cycle k+3.
- Each already-tried cell probed adds 1 cycle. Worst case: `done` at k+3+N for the exhausted report.
- `hp_player` and the tried map update at the same edge that enters REPORT. Both are visible while `done` = 1.
- Back-to-back: `start` held high is re-accepted in the IDLE cycle after REPORT, giving a minimum period of 4 cycles.

## Configuration
- `PC_ATTACK_HUNT_EN` defined:
  - Block keeps a `pending` flag and last-hit index. Both are set on a hit and cleared by reset or `new_game`.
  - In PICK with `pending` = 1, candidate = first in-board untried neighbour of the last hit, in order up, right, down, left. The LFSR still advances.
  - If no neighbour qualifies, `pending` clears and the random pick is used. Latency is unchanged.
- Undefined: purely random pick; no hunt state is synthesized.

## Test plan
- Reset, `ship_map` = 0, pulse `start` → `done` in cycle k+3; `shot_row` = 1, `shot_col` = 0 (index 5 from seed 8'hA5); `hit` = 0; `hp_player` = 5.
- `ship_map` bit 5 = 1, same sequence → `hit` = 1, `hp_player` = 4 when `done` rises.
- Preload the tried map by firing repeatedly until index 5 is tried; force the LFSR candidate to 5 → block scans and fires at index 6; `done` is delayed one cycle per tried cell probed.
- Fire 25 shots with `ship_map` all 1 → `hp_player` reaches 0 and stays 0; the 26th `start` gives `done` at k+3+25 with `exhausted` = 1, `shot_valid` = 0.
- `new_game` asserted during SCAN → IDLE next cycle, `done` never pulses, `hp_player` = 5, next shot may reuse earlier cells.
- With `PC_ATTACK_HUNT_EN`: hit at row 2, col 2 → next shot at row 1, col 2; with row 1, col 2 already tried → next shot at row 2, col 3.
